// File: rtl/uart_pkg.sv
// Shared UART timing helpers (also used by uart_tx) and the arbiter FSM encoding.
package uart_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t WAIT = 2'd2;

    // Must stay bit-identical to the divider uart_tx derives.
    function automatic int uart_div(input int clk, input int baud);
        return clk / baud;
    endfunction

    function automatic int uart_frame_cycles(input int clk, input int baud,
                                             input int bits, input int gap);
        return (bits + 2) * uart_div(clk, baud) + gap;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake plus the send/data pair that feeds uart_tx.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BITS  = 8
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*BITS-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  tx_send;
    logic [BITS-1:0]       tx_data;
    logic                  busy;
    logic [IW-1:0]         grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_send, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_send, tx_data, busy, grant_id
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_req
);
    localparam int IW = $clog2(N);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte sources; the frame is
// timed locally because uart_tx exposes no busy/done indication.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK        = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int BITS       = 8,
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int DIV   = uart_div(CLK, BAUD_RATE);
    localparam int FRAME = uart_frame_cycles(CLK, BAUD_RATE, BITS, GAP_CYCLES);
    localparam int CW    = $clog2(FRAME + 1);
    localparam int IW    = $clog2(N_REQ);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("uart_tx_arbiter: CLK/BAUD_RATE must be at least 2");
        end
        if (N_REQ < 2 || N_REQ > 16) begin : g_nreq_chk
            $error("uart_tx_arbiter: N_REQ must be in 2..16");
        end
    endgenerate

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic [N_REQ-1:0] ready_q;
    logic            send_q;
    logic [BITS-1:0] data_q;
    logic            busy_q;
    logic [IW-1:0]   gid_q;

    logic [N_REQ-1:0] win_grant;
    logic [IW-1:0]    win_idx;
    logic             any_req;
    logic [BITS-1:0]  win_data;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .grant   (win_grant),
        .idx     (win_idx),
        .any_req (any_req)
    );

    assign win_data = bus.req_data[int'(win_idx)*BITS +: BITS];

    // Counter covers FRAME-1 down to 0 plus the SEND and accept cycles, so
    // send-to-send spacing is FRAME+2 and uart_tx is always idle first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            ready_q <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            ready_q <= '0;
            send_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        data_q  <= win_data;
                        gid_q   <= win_idx;
                        ready_q <= win_grant;
                        ptr     <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                        busy_q  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    send_q <= 1'b1;
                    cnt    <= CNT_LOAD;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.tx_send   = send_q;
    assign bus.tx_data   = data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and line decoder.
module tb_uart_tx_arbiter;
    localparam int CLK_HZ = 8;
    localparam int BAUD   = 1;
    localparam int BITS   = 8;
    localparam int NR     = 4;
    localparam int GAP    = 0;
    localparam int DIV    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(NR), .BITS(BITS)) bus ();

    uart_tx_arbiter #(
        .CLK(CLK_HZ), .BAUD_RATE(BAUD), .BITS(BITS), .N_REQ(NR), .GAP_CYCLES(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: no reset, re-reads tx_data at every bit boundary
    logic line = 1'b1;
    logic m_busy = 1'b0;
    int   m_cnt = 0;
    int   m_bit = 0;
    int   overlap = 0;
    always @(posedge clk) begin
        if (!m_busy) begin
            line <= 1'b1;
            if (bus.tx_send) begin
                m_busy <= 1'b1; m_bit <= 0; m_cnt <= DIV - 1; line <= 1'b0;
            end
        end else begin
            if (bus.tx_send) overlap <= overlap + 1;
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            else begin
                m_cnt <= DIV - 1;
                if (m_bit < BITS) begin line <= bus.tx_data[m_bit]; m_bit <= m_bit + 1; end
                else if (m_bit == BITS) begin line <= 1'b1; m_bit <= m_bit + 1; end
                else m_busy <= 1'b0;
            end
        end
    end

    // Line decoder: samples mid-bit, queues {stop, byte}
    logic [8:0] rx_q[$];
    logic [7:0] rx_b;
    initial begin
        forever begin
            @(negedge clk);
            if (line === 1'b0) begin
                repeat (DIV/2 - 1) @(negedge clk);
                for (int k = 0; k < BITS; k++) begin
                    repeat (DIV) @(negedge clk);
                    rx_b[k] = line;
                end
                repeat (DIV) @(negedge clk);
                rx_q.push_back({line, rx_b});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp);
        logic [8:0] v;
        if (rx_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no byte on line, want %h", nm, exp);
        end else begin
            v = rx_q.pop_front();
            chk(nm, {23'd0, v}, {23'd0, 1'b1, exp});
        end
    endtask

    task automatic wait_ready(input string nm, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (|bus.req_ready) begin ok = 1; break; end
        end
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL %s: no req_ready within %0d cycles", nm, lim); end
    endtask

    task automatic wait_send(input string nm, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (bus.tx_send) begin ok = 1; break; end
        end
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL %s: no tx_send within %0d cycles", nm, lim); end
    endtask

    task automatic wait_idle(input string nm, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin ok = 1; break; end
        end
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL %s: busy stuck for %0d cycles", nm, lim); end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t tbl[8];

    int last_send;
    int frame_bits[10];
    logic [7:0] seen;

    initial begin
        // Pointer enters the table at 0; expected winners track it by hand
        tbl[0] = '{4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
        tbl[1] = '{4'b0001, 32'hDDCCBBAA, 4'b0001, 2'd0, 8'hAA};
        tbl[2] = '{4'b1001, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        tbl[3] = '{4'b1100, 32'h8899EEFF, 4'b0100, 2'd2, 8'h99};
        tbl[4] = '{4'b0110, 32'h01020304, 4'b0010, 2'd1, 8'h03};
        tbl[5] = '{4'b0010, 32'h00007E00, 4'b0010, 2'd1, 8'h7E};
        tbl[6] = '{4'b1000, 32'h81000000, 4'b1000, 2'd3, 8'h81};
        tbl[7] = '{4'b1010, 32'hF0000F00, 4'b0010, 2'd1, 8'h0F};

        // Reset held with every requester valid
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h13121110;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_send",  bus.tx_send, 0);
        chk("rst_data",  bus.tx_data, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_gid",   bus.grant_id, 0);
        @(negedge clk) rst_n = 1'b1;

        // All four valid: grants 0..3, sends FRAME+2 apart
        for (int g = 0; g < NR; g++) begin
            wait_ready($sformatf("all_rdy%0d", g), 200);
            chk($sformatf("all_gid%0d", g), bus.grant_id, g);
            chk($sformatf("all_onehot%0d", g), bus.req_ready, 1 << g);
            bus.req_valid[g] = 1'b0;
            wait_send($sformatf("all_send%0d", g), 5);
            chk($sformatf("all_data%0d", g), bus.tx_data, 8'h10 + g);
            if (g > 0) chk($sformatf("all_gap%0d", g), cyc - last_send, 82);
            last_send = cyc;
        end
        wait_idle("all_idle", 200);
        repeat (3) @(posedge clk);
        for (int g = 0; g < NR; g++) chk_rx($sformatf("all_rx%0d", g), 8'h10 + g);

        // Fairness: 1 and 3 held valid for 10 frames
        #1;
        bus.req_data  = 32'hB300B100;
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            wait_ready($sformatf("fair_rdy%0d", k), 200);
            chk($sformatf("fair_gid%0d", k), bus.grant_id, (k % 2 == 0) ? 1 : 3);
            if (k == 9) bus.req_valid = 4'b0000;
        end
        wait_idle("fair_idle", 200);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 10; k++) chk_rx($sformatf("fair_rx%0d", k), (k % 2 == 0) ? 8'hB1 : 8'hB3);

        // Table-driven arbitration vectors
        foreach (tbl[i]) begin
            #1;
            bus.req_valid = tbl[i].valid;
            bus.req_data  = tbl[i].data;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_gid", i),   bus.grant_id,  tbl[i].exp_id);
            chk($sformatf("tbl%0d_data", i),  bus.tx_data,   tbl[i].exp_data);
            bus.req_valid = 4'b0000;
            wait_send($sformatf("tbl%0d_send", i), 5);
            wait_idle($sformatf("tbl%0d_idle", i), 200);
            repeat (3) @(posedge clk);
            chk_rx($sformatf("tbl%0d_rx", i), tbl[i].exp_data);
        end

        // Single request: exact latency and bit-level line timing
        #1;
        bus.req_data  = 32'h00A50000;
        bus.req_valid = 4'b0100;
        @(posedge clk); #1;
        chk("one_ready_c1", bus.req_ready, 4'b0100);
        chk("one_send_c1",  bus.tx_send, 0);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("one_send_c2",  bus.tx_send, 1);
        chk("one_ready_c2", bus.req_ready, 0);
        frame_bits[0] = 0;
        for (int j = 0; j < 8; j++) frame_bits[j+1] = (8'hA5 >> j) & 1;
        frame_bits[9] = 1;
        repeat (5) @(posedge clk);
        #1;
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("one_line%0d", j), line, frame_bits[j]);
            if (j < 9) begin repeat (8) @(posedge clk); #1; end
        end
        repeat (2) @(posedge clk); #1;
        chk("one_busy_c81", bus.busy, 1);
        repeat (2) @(posedge clk); #1;
        chk("one_busy_c83", bus.busy, 0);
        chk_rx("one_rx", 8'hA5);

        // Data hold: source changes its word right after accept
        bus.req_data  = 32'h0000003C;
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        chk("hold_ready", bus.req_ready, 4'b0001);
        bus.req_data  = 32'h000000FF;
        bus.req_valid = 4'b0000;
        seen = 8'h3C;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1;
            if (bus.tx_data !== 8'h3C) seen = bus.tx_data;
        end
        chk("hold_tx_data", seen, 8'h3C);
        chk_rx("hold_rx", 8'h3C);
        bus.req_valid = 4'b0001;
        @(posedge clk); #1;
        chk("hold_next", bus.tx_data, 8'hFF);
        bus.req_valid = 4'b0000;

        // Reset 40 cycles into WAIT
        wait_send("mid_send", 5);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_send0", bus.tx_send, 0);
        chk("mid_data", bus.tx_data, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(posedge clk);
        rx_q.delete();
        #1;
        bus.req_data  = 32'h77000000;
        bus.req_valid = 4'b1000;
        @(posedge clk); #1;
        chk("mid_fresh_ready", bus.req_ready, 4'b1000);
        chk("mid_fresh_gid", bus.grant_id, 3);
        bus.req_valid = 4'b0000;
        wait_idle("mid_idle", 200);
        repeat (3) @(posedge clk);
        chk_rx("mid_rx", 8'h77);

        chk("no_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
